// File: rtl/minx_bus_pkg.sv
// Shared MinX bus definitions: bus command encodings, arbiter state type and master limits.
// Used by bus_arbiter and its picker (BUS_ARBITER_ROUND_ROBIN_EN selects rotating priority there).
package minx_bus_pkg;

  localparam int MAX_MASTERS = 4;

  typedef logic [1:0] bus_status_t;
  typedef logic [$clog2(MAX_MASTERS)-1:0] master_idx_t;

  localparam bus_status_t BUS_COMMAND_IDLE      = 2'd0;
  localparam bus_status_t BUS_COMMAND_IRQ_READ  = 2'd1;
  localparam bus_status_t BUS_COMMAND_MEM_WRITE = 2'd2;
  localparam bus_status_t BUS_COMMAND_MEM_READ  = 2'd3;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_WAIT_ACK,
    ARB_GRANT,
    ARB_HANDOVER,
    ARB_RELEASE
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational next-owner picker: fixed priority (index 0 highest) by default,
// rotating priority from `start` when BUS_ARBITER_ROUND_ROBIN_EN is defined.
module bus_arbiter_pick
  import minx_bus_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0] req,
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  input  master_idx_t          start,
`endif
  input  logic                 excl_valid,
  input  master_idx_t          excl_idx,
  output logic                 valid,
  output master_idx_t          idx
);

  logic [N_MASTERS-1:0] cand;

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      cand[i] = req[i] && !(excl_valid && (excl_idx == master_idx_t'(i)));
    end
  end

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  int pos;

  // Walk offsets from the far end so the closest candidate after `start` wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      for (int j = 0; j < N_MASTERS; j++) begin
        pos = int'(start) + k;
        if (pos >= N_MASTERS) pos = pos - N_MASTERS;
        if (pos == j && cand[j]) begin
          valid = 1'b1;
          idx   = master_idx_t'(j);
        end
      end
    end
  end
`else
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        valid = 1'b1;
        idx   = master_idx_t'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// MinX bus arbiter: sequences bus ownership between the CPU and up to four masters
// and muxes the shared bus. BUS_ARBITER_ROUND_ROBIN_EN enables rotating priority.
module bus_arbiter
  import minx_bus_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_ce,
  input  logic [N_MASTERS-1:0]        req,
  output logic [N_MASTERS-1:0]        grant,
  input  logic [N_MASTERS-1:0][23:0]  m_address,
  input  logic [N_MASTERS-1:0][7:0]   m_data,
  input  logic [N_MASTERS-1:0]        m_read,
  input  logic [N_MASTERS-1:0]        m_write,
  input  bus_status_t [N_MASTERS-1:0] m_bus_status,
  input  logic [23:0]                 cpu_address,
  input  logic [7:0]                  cpu_data,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  input  bus_status_t                 cpu_bus_status,
  output logic                        cpu_bus_request,
  input  logic                        cpu_bus_ack,
  output logic [23:0]                 bus_address_out,
  output logic [7:0]                  bus_data_out,
  output logic                        bus_read,
  output logic                        bus_write,
  output bus_status_t                 bus_status,
  output logic                        bus_owned,
  output master_idx_t                 owner
);

  arb_state_t           state, state_n;
  logic [N_MASTERS-1:0] grant_n;
  logic                 bus_request_n;
  master_idx_t          owner_n;

  logic                 pick_valid;
  master_idx_t          pick_idx;

  logic                 own_req;
  logic [23:0]          own_address;
  logic [7:0]           own_data;
  logic                 own_read;
  logic                 own_write;
  bus_status_t          own_status;

  logic [23:0]          hold_address;
  logic [7:0]           hold_data;

  function automatic logic [N_MASTERS-1:0] onehot(input master_idx_t idx);
    logic [N_MASTERS-1:0] v;
    for (int i = 0; i < N_MASTERS; i++) v[i] = (idx == master_idx_t'(i));
    return v;
  endfunction

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  master_idx_t rr_ptr, rr_ptr_n;

  function automatic master_idx_t after(input master_idx_t idx);
    return (idx == master_idx_t'(N_MASTERS - 1)) ? '0 : idx + 1'b1;
  endfunction
`endif

  bus_arbiter_pick #(.N_MASTERS(N_MASTERS)) u_pick (
    .req        (req),
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    .start      (rr_ptr),
`endif
    .excl_valid (state == ARB_GRANT),
    .excl_idx   (owner),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Select the current owner's request and bus fields.
  always_comb begin
    own_req     = 1'b0;
    own_address = '0;
    own_data    = '0;
    own_read    = 1'b0;
    own_write   = 1'b0;
    own_status  = BUS_COMMAND_IDLE;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (owner == master_idx_t'(i)) begin
        own_req     = req[i];
        own_address = m_address[i];
        own_data    = m_data[i];
        own_read    = m_read[i];
        own_write   = m_write[i];
        own_status  = m_bus_status[i];
      end
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    bus_request_n = cpu_bus_request;
    owner_n       = owner;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    rr_ptr_n      = rr_ptr;
`endif
    unique case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_n       = pick_idx;
          bus_request_n = 1'b1;
          state_n       = ARB_WAIT_ACK;
        end
      end
      ARB_WAIT_ACK: begin
        if (!own_req) begin
          bus_request_n = 1'b0;
          state_n       = ARB_RELEASE;
        end else if (cpu_bus_ack) begin
          grant_n = onehot(owner);
          state_n = ARB_GRANT;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
          rr_ptr_n = after(owner);
`endif
        end
      end
      ARB_GRANT: begin
        if (!own_req) begin
          grant_n = '0;
          if (pick_valid) begin
            owner_n = pick_idx;
            state_n = ARB_HANDOVER;
          end else begin
            bus_request_n = 1'b0;
            state_n       = ARB_RELEASE;
          end
        end
      end
      ARB_HANDOVER: begin
        grant_n = onehot(owner);
        state_n = ARB_GRANT;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        rr_ptr_n = after(owner);
`endif
      end
      ARB_RELEASE: begin
        if (!cpu_bus_ack) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ARB_IDLE;
      grant           <= '0;
      cpu_bus_request <= 1'b0;
      owner           <= '0;
    end else if (clk_ce) begin
      state           <= state_n;
      grant           <= grant_n;
      cpu_bus_request <= bus_request_n;
      owner           <= owner_n;
    end
  end

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= '0;
    else if (clk_ce) rr_ptr <= rr_ptr_n;
  end
`endif

  // NOTE: pure datapath holding registers need no reset; they are only shown after a GRANT cycle has loaded them.
  always_ff @(posedge clk) begin
    if (clk_ce && state == ARB_GRANT) begin
      hold_address <= own_address;
      hold_data    <= own_data;
    end
  end

  assign bus_owned = (|grant) & cpu_bus_ack;

  always_comb begin
    bus_address_out = cpu_address;
    bus_data_out    = cpu_data;
    bus_read        = cpu_read;
    bus_write       = cpu_write;
    bus_status      = cpu_bus_status;
    if (bus_owned) begin
      bus_address_out = own_address;
      bus_data_out    = own_data;
      bus_read        = own_read;
      bus_write       = own_write;
      bus_status      = own_status;
    end else if (state == ARB_HANDOVER) begin
      // Strobes quiet between owners; address/data stay parked on the outgoing master's last values.
      bus_address_out = hold_address;
      bus_data_out    = hold_data;
      bus_read        = 1'b0;
      bus_write       = 1'b0;
      bus_status      = BUS_COMMAND_IDLE;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios, then randomized traffic
// against a tenure-level reference model of the ownership rules.
module tb_bus_arbiter;
  import minx_bus_pkg::*;

  localparam int N  = 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                clk_ce;
  logic [N-1:0]        req;
  logic [N-1:0]        grant;
  logic [N-1:0][23:0]  m_address;
  logic [N-1:0][7:0]   m_data;
  logic [N-1:0]        m_read;
  logic [N-1:0]        m_write;
  bus_status_t [N-1:0] m_bus_status;
  logic [23:0]         cpu_address;
  logic [7:0]          cpu_data;
  logic                cpu_read;
  logic                cpu_write;
  bus_status_t         cpu_bus_status;
  logic                cpu_bus_request;
  logic                cpu_bus_ack;
  logic [23:0]         bus_address_out;
  logic [7:0]          bus_data_out;
  logic                bus_read;
  logic                bus_write;
  bus_status_t         bus_status;
  logic                bus_owned;
  master_idx_t         owner;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.N_MASTERS(N)) dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .req(req), .grant(grant),
    .m_address(m_address), .m_data(m_data), .m_read(m_read), .m_write(m_write),
    .m_bus_status(m_bus_status), .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status),
    .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
    .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .bus_read(bus_read), .bus_write(bus_write), .bus_status(bus_status),
    .bus_owned(bus_owned), .owner(owner)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the bus, whether the CPU is being asked, handover gap, release wait.
  logic [IW-1:0] m_owner;
  int            m_ptr;
  bit            m_breq, m_gnt, m_gap, m_rel;
  logic [23:0]   m_hold_a;
  logic [7:0]    m_hold_d;
  int            hold_cnt [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int excl, input int start);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      t = r >> i;
      if (t[0] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic int search_start();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    return m_ptr;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    int p;
    if (reset) begin
      m_owner = '0; m_ptr = 0; m_breq = 0; m_gnt = 0; m_gap = 0; m_rel = 0;
      return;
    end
    if (!clk_ce) return;
    if (m_gnt) begin
      m_hold_a = m_address[m_owner];
      m_hold_d = m_data[m_owner];
    end
    if (m_rel) begin
      if (!cpu_bus_ack) m_rel = 0;
    end else if (!m_breq) begin
      p = pick(req, -1, search_start());
      if (p >= 0) begin m_owner = IW'(p); m_breq = 1; end
    end else if (m_gap) begin
      m_gap = 0; m_gnt = 1; m_ptr = (int'(m_owner) + 1) % N;
    end else if (m_gnt) begin
      if (!req[m_owner]) begin
        m_gnt = 0;
        p = pick(req, int'(m_owner), search_start());
        if (p >= 0) begin m_owner = IW'(p); m_gap = 1; end
        else begin m_breq = 0; m_rel = 1; end
      end
    end else begin
      if (!req[m_owner]) begin m_breq = 0; m_rel = 1; end
      else if (cpu_bus_ack) begin m_gnt = 1; m_ptr = (int'(m_owner) + 1) % N; end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = '0;
    if (m_gnt) eg[m_owner] = 1'b1;
    check("grant", grant, eg);
    check("cpu_bus_request", cpu_bus_request, m_breq);
    check("owner", owner, m_owner);
    check("bus_owned", bus_owned, m_gnt && cpu_bus_ack);
    if (m_gnt && cpu_bus_ack) begin
      check("addr_m", bus_address_out, m_address[m_owner]);
      check("data_m", bus_data_out, m_data[m_owner]);
      check("read_m", bus_read, m_read[m_owner]);
      check("write_m", bus_write, m_write[m_owner]);
      check("status_m", bus_status, m_bus_status[m_owner]);
    end else if (m_gap) begin
      check("addr_gap", bus_address_out, m_hold_a);
      check("data_gap", bus_data_out, m_hold_d);
      check("read_gap", bus_read, 1'b0);
      check("write_gap", bus_write, 1'b0);
      check("status_gap", bus_status, BUS_COMMAND_IDLE);
    end else begin
      check("addr_cpu", bus_address_out, cpu_address);
      check("data_cpu", bus_data_out, cpu_data);
      check("read_cpu", bus_read, cpu_read);
      check("write_cpu", bus_write, cpu_write);
      check("status_cpu", bus_status, cpu_bus_status);
    end
  endtask

  // Inputs change only at posedge+1; the model steps on the same edge the DUT does.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic scramble_bus();
    cpu_address    = 24'($urandom);
    cpu_data       = 8'($urandom);
    cpu_read       = 1'($urandom);
    cpu_write      = 1'($urandom);
    cpu_bus_status = 2'($urandom);
    for (int i = 0; i < N; i++) begin
      m_data[i]       = 8'($urandom);
      m_bus_status[i] = 2'($urandom);
    end
    m_read  = N'($urandom);
    m_write = N'($urandom);
  endtask

  initial begin
    m_owner = '0; m_ptr = 0; m_breq = 0; m_gnt = 0; m_gap = 0; m_rel = 0;
    m_hold_a = '0; m_hold_d = '0;
    reset = 1'b1; clk_ce = 1'b1; req = '0; cpu_bus_ack = 1'b0;
    m_address[0] = 24'h001000;
    m_address[1] = 24'h002000;
    m_data = '0; m_read = '0; m_write = '0; m_bus_status = '0;
    cpu_address = 24'h0; cpu_data = 8'h0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_bus_status = BUS_COMMAND_IDLE;
    for (int i = 0; i < N; i++) hold_cnt[i] = 0;

    tick();
    reset = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_breq", cpu_bus_request, 0);
    check("rst_owner", owner, 0);
    check("rst_owned", bus_owned, 0);

    // CPU pass-through write with no requests
    cpu_address = 24'h002061; cpu_data = 8'h5A; cpu_write = 1'b1;
    cpu_bus_status = BUS_COMMAND_MEM_WRITE;
    tick();
    check("pt_write", bus_write, 1);
    check("pt_data", bus_data_out, 8'h5A);
    check("pt_addr", bus_address_out, 24'h002061);
    check("pt_owned", bus_owned, 0);
    check("pt_grant", grant, 0);
    cpu_write = 1'b0;

    // Single grant: ack arrives three cycles after the request
    req = 2'b01;
    tick();
    check("sg_breq", cpu_bus_request, 1);
    tick();
    tick();
    cpu_bus_ack = 1'b1;
    tick();
    check("sg_grant", grant, 2'b01);
    check("sg_addr", bus_address_out, 24'h001000);
    check("sg_owned", bus_owned, 1);
    tick();
    req = 2'b00;
    tick();
    check("sg_grant_drop", grant, 0);
    check("sg_breq_drop", cpu_bus_request, 0);
    cpu_bus_ack = 1'b0;
    tick();

    // Cancel: master 1 requests for two cycles, never acked
    req = 2'b10;
    tick();
    check("cx_breq", cpu_bus_request, 1);
    check("cx_owner", owner, 1);
    tick();
    req = 2'b00;
    tick();
    check("cx_breq_fall", cpu_bus_request, 0);
    check("cx_grant", grant, 0);
    tick();

    // Contention, two bursts: 0 then 1 each time with one quiet handover cycle
    m_read = 2'b11; cpu_read = 1'b1;
    for (int b = 0; b < 2; b++) begin
      req = 2'b11;
      tick();
      check("ct_owner0", owner, 0);
      cpu_bus_ack = 1'b1;
      tick();
      check("ct_grant0", grant, 2'b01);
      tick();
      req = 2'b10;
      tick();
      check("ct_gap_grant", grant, 0);
      check("ct_gap_read", bus_read, 0);
      check("ct_gap_write", bus_write, 0);
      check("ct_gap_breq", cpu_bus_request, 1);
      check("ct_gap_owner", owner, 1);
      tick();
      check("ct_grant1", grant, 2'b10);
      check("ct_breq1", cpu_bus_request, 1);
      req = 2'b00;
      tick();
      cpu_bus_ack = 1'b0;
      tick();
    end

    // Reset while master 1 owns the bus
    req = 2'b10;
    tick();
    cpu_bus_ack = 1'b1;
    tick();
    check("rg_grant", grant, 2'b10);
    reset = 1'b1; cpu_address = 24'h0ABCDE; cpu_read = 1'b0;
    tick();
    reset = 1'b0;
    check("rg_grant0", grant, 0);
    check("rg_breq0", cpu_bus_request, 0);
    check("rg_owner0", owner, 0);
    check("rg_addr_cpu", bus_address_out, 24'h0ABCDE);
    check("rg_read_cpu", bus_read, 0);
    req = 2'b00; cpu_bus_ack = 1'b0;
    tick();

    // Randomized traffic with protocol-following masters and CPU
    for (int c = 0; c < 4000; c++) begin
      clk_ce = ($urandom_range(3) != 0);
      reset  = ($urandom_range(499) == 0);
      scramble_bus();
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            hold_cnt[i] = $urandom_range(4, 1);
          end
        end else if (m_gnt && int'(m_owner) == i) begin
          if (hold_cnt[i] > 0) hold_cnt[i]--;
          else req[i] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (m_breq && !cpu_bus_ack) begin
        if ($urandom_range(2) == 0) cpu_bus_ack = 1'b1;
      end else if (!m_breq && cpu_bus_ack) begin
        if ($urandom_range(1) == 0) cpu_bus_ack = 1'b0;
      end else if (!m_breq && $urandom_range(63) == 0) begin
        cpu_bus_ack = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequences ownership of the MinX system bus between the S1C88 CPU and up to four DMA-style masters, such as the PRC and a future save-state/debug loader. It collects master requests and drives the CPU `bus_request`/`bus_ack` handshake. It returns a one-hot grant and muxes the owning master's address, data and strobes onto the shared bus. It sits in `minx` between the masters, the CPU and the register/memory decode, replacing the ad-hoc single-master muxing.

## Interface
Parameters:
- `N_MASTERS`, default 2, number of requesters (legal range 1..4); index 0 is the PRC.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high).
- `clk_ce`  in  1  CPU-rate enable; all state advances only when high.
- `req`  in  N_MASTERS  per-master bus request, level, held for the whole tenure.
- `grant`  out  N_MASTERS  one-hot ownership; master may drive strobes only while its bit is high.
- `m_address`  in  N_MASTERS×24  per-master address.
- `m_data`  in  N_MASTERS×8  per-master write data.
- `m_read`, `m_write`  in  N_MASTERS  per-master strobes.
- `m_bus_status`  in  N_MASTERS×2  per-master bus command.
- `cpu_address`, `cpu_data`, `cpu_read`, `cpu_write`, `cpu_bus_status`  in  24/8/1/1/2  CPU bus outputs.
- `cpu_bus_request`  out  1  to the CPU; asks it to release the bus at the next instruction boundary.
- `cpu_bus_ack`  in  1  from the CPU; bus released.
- `bus_address_out`, `bus_data_out`, `bus_read`, `bus_write`, `bus_status`  out  24/8/1/1/2  muxed shared bus.
- `bus_owned`  out  1  a master currently owns the bus; this is the bus_ack seen by peripherals.
- `owner`  out  2  index of the current or pending owner.

## Operation
- States: IDLE, WAIT_ACK, GRANT, HANDOVER, RELEASE.
- IDLE: on `clk_ce`, if any `req` is set, run the picker and latch `owner`. Set `cpu_bus_request`=1 and go to WAIT_ACK.
- WAIT_ACK: if `req[owner]`=0, this is a cancel: clear `cpu_bus_request` and go to RELEASE. Else if `cpu_bus_ack`=1, set `grant[owner]`=1 and go to GRANT.
- GRANT: hold while `req[owner]`=1. When it drops, clear `grant`.
  - If any other request is pending, pick the next owner and go to HANDOVER, keeping `cpu_bus_request`=1.
  - Otherwise clear `cpu_bus_request` and go to RELEASE.
- HANDOVER: exactly one `clk_ce` cycle with no grant. Then set `grant[owner]`=1 and go to GRANT. The CPU is not re-entered between back-to-back masters.
- RELEASE: wait for `cpu_bus_ack`=0, then go to IDLE. Requests arriving in RELEASE wait for IDLE.
- Bus mux:
  - If `bus_owned`=`|grant & cpu_bus_ack`, outputs come from master `owner`.
  - In HANDOVER, read and write are 0, status is `BUS_COMMAND_IDLE`, and address/data keep the previous owner's value.
  - In all other states, outputs are CPU pass-through.
- Picker: fixed priority, lowest index wins, unless the macro below is defined.
- A `req` bit that rises and falls between `clk_ce` pulses is not guaranteed to be seen; masters hold `req` until `grant`.
- `cpu_bus_ack` rising while in IDLE or RELEASE is ignored; no grant is issued.

## Timing
- Reset values: state IDLE; `grant`=0; `cpu_bus_request`=0; `owner`=0; `bus_owned`=0; rotation pointer 0. Bus outputs are CPU pass-through.
- Reset mid-tenure takes effect at the next `clk` edge, regardless of `clk_ce`. Grant drops; no completion is waited for.
- Request to `cpu_bus_request`: 1 `clk_ce` cycle (registered).
- `cpu_bus_ack` to `grant`: 1 `clk_ce` cycle.
- `req` drop to `grant` drop: 1 `clk_ce` cycle.
- Handover gap: exactly 1 idle `clk_ce` cycle between grants.
- `grant`, `cpu_bus_request` and `owner` are registered.
- The bus mux is combinational on registered select plus `cpu_bus_ack`.
- Simultaneous requests in IDLE: one winner; losers stay pending and are served via HANDOVER.
- `N_MASTERS`=1: the picker degenerates to `req[0]`, and the rotating pointer is unused.

## Configuration
- `BUS_ARBITER_ROUND_ROBIN_EN`:
  - Defined: rotating priority. The search starts at (last granted owner + 1) mod `N_MASTERS`. The pointer updates on each grant.
  - Undefined: fixed priority, index 0 highest, and no pointer register exists.

## Structure
- Shared package `minx_bus_pkg` holds:
  - the bus command encodings `BUS_COMMAND_IDLE`, `BUS_COMMAND_IRQ_READ`, `BUS_COMMAND_MEM_WRITE`, `BUS_COMMAND_MEM_READ`;
  - the `bus_status_t` typedef;
  - the `arb_state_t` enum;
  - `MAX_MASTERS`=4.
- Sub-module `bus_arbiter_pick`: combinational picker taking `req`, the start pointer and the excluded current owner. It returns a valid flag and an index, with fixed/rotating behaviour selected by the macro.

## Test plan
- Single grant: `req[0]`=1, CPU acks 3 `clk_ce` later. Required: `cpu_bus_request`=1 after 1 cycle; `grant`=01 one cycle after ack; `bus_address_out`=`m_address[0]`=24'h001000. Drop req → `grant`=0 → `cpu_bus_request`=0.
- Cancel: `req[1]` pulses for 2 cycles with no ack. Required: no grant ever; `cpu_bus_request` falls; IDLE after `cpu_bus_ack`=0.
- Contention: `req`=11 together.
  - Fixed priority: order 0 then 1, one HANDOVER cycle with `bus_read`=`bus_write`=0, and `cpu_bus_request` high throughout.
  - With the macro, repeated bursts alternate 0,1,0,1.
- Reset mid-GRANT on `owner`=1. Required: next clock `grant`=0, `cpu_bus_request`=0, `owner`=0, and bus outputs equal the CPU inputs.
- Pass-through: no requests, CPU writes 8'h5A to 24'h2061. Required: `bus_write`=1, `bus_data_out`=8'h5A, `bus_owned`=0, `grant`=0.
